// File: rtl/id_operand_stage_pkg.sv
// Shared constants, forwarding-source tuple and match helper for the ID operand stage.
package id_operand_stage_pkg;

  localparam int          DATA_W   = 32;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          REG_W    = 5;
  localparam int          RS_LSB   = 21;
  localparam int          RT_LSB   = 16;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  dest;
    logic              is_load;
    logic              data_ok;
    logic [DATA_W-1:0] result;
  } fwd_src_t;

  // A stage only produces a value for src when it is live and writes a real register.
  function automatic logic reg_match(input fwd_src_t s, input logic [REG_W-1:0] src);
    return s.valid && (s.dest != REG_ZERO) && (s.dest == src);
  endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Bundle of IF/ID/EX handshake, regfile read and stage-forwarding signals around the ID stage.
interface id_operand_stage_if;
  import id_operand_stage_pkg::*;

  logic              flush;
  logic              fs_to_ds_valid;
  logic [31:0]       fs_pc;
  logic [31:0]       fs_inst;
  logic              ds_allowin;
  logic [REG_W-1:0]  raddr1;
  logic [REG_W-1:0]  raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              es_valid;
  logic [REG_W-1:0]  es_dest;
  logic              es_is_load;
  logic [DATA_W-1:0] es_result;
  logic              ms_valid;
  logic [REG_W-1:0]  ms_dest;
  logic              ms_is_load;
  logic              ms_data_ok;
  logic [DATA_W-1:0] ms_result;
  logic              ws_valid;
  logic [REG_W-1:0]  ws_dest;
  logic [DATA_W-1:0] ws_result;
  logic              es_allowin;
  logic              ds_to_es_valid;
  logic [31:0]       ds_pc;
  logic [31:0]       ds_inst;
  logic [DATA_W-1:0] ds_src1;
  logic [DATA_W-1:0] ds_src2;

  modport slave (
    input  flush, fs_to_ds_valid, fs_pc, fs_inst, rdata1, rdata2,
           es_valid, es_dest, es_is_load, es_result,
           ms_valid, ms_dest, ms_is_load, ms_data_ok, ms_result,
           ws_valid, ws_dest, ws_result, es_allowin,
    output ds_allowin, raddr1, raddr2, ds_to_es_valid, ds_pc, ds_inst, ds_src1, ds_src2
  );

  modport master (
    output flush, fs_to_ds_valid, fs_pc, fs_inst, rdata1, rdata2,
           es_valid, es_dest, es_is_load, es_result,
           ms_valid, ms_dest, ms_is_load, ms_data_ok, ms_result,
           ws_valid, ws_dest, ws_result, es_allowin,
    input  ds_allowin, raddr1, raddr2, ds_to_es_valid, ds_pc, ds_inst, ds_src1, ds_src2
  );

endinterface

// File: rtl/id_operand_stage_fwd_mux.sv
// Per-operand hazard resolution: picks EX/MEM/WB/regfile value and flags a stall.
// BYPASS_EN selects the forwarding network; otherwise any in-flight writer stalls.
module id_fwd_mux
  import id_operand_stage_pkg::*;
(
  input  logic [REG_W-1:0]  i_src,
  input  fwd_src_t          i_es,
  input  fwd_src_t          i_ms,
  input  fwd_src_t          i_ws,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_value,
  output logic              o_stall
);

  logic w_es_hit;
  logic w_ms_hit;
  logic w_ws_hit;
  logic w_unused;

  assign w_es_hit = reg_match(i_es, i_src);
  assign w_ms_hit = reg_match(i_ms, i_src);
  assign w_ws_hit = reg_match(i_ws, i_src);

`ifdef BYPASS_EN
  assign w_unused = ^{i_es.data_ok, i_ws.is_load, i_ws.data_ok};

  // Youngest producer wins; loads without data yet cannot be forwarded.
  always_comb begin
    o_value = i_rdata;
    o_stall = (w_es_hit && i_es.is_load) ||
              (w_ms_hit && i_ms.is_load && !i_ms.data_ok);
    if (i_src == REG_ZERO)
      o_value = '0;
    else if (w_es_hit)
      o_value = i_es.result;
    else if (w_ms_hit)
      o_value = i_ms.result;
    else if (w_ws_hit)
      o_value = i_ws.result;
  end
`else
  assign w_unused = ^{i_es.is_load, i_es.data_ok, i_es.result,
                      i_ms.is_load, i_ms.data_ok, i_ms.result,
                      i_ws.is_load, i_ws.data_ok, i_ws.result};

  always_comb begin
    o_value = (i_src == REG_ZERO) ? '0 : i_rdata;
    o_stall = w_es_hit || w_ms_hit || w_ws_hit;
  end
`endif

endmodule

// File: rtl/id_operand_stage.sv
// ID pipeline register with valid/allowin handshake, regfile addressing and RAW resolution.
// BYPASS_EN enables EX/MEM/WB forwarding; default build stalls until the writer retires.
module id_operand_stage #(
  parameter int          DATA_W   = id_operand_stage_pkg::DATA_W,
  parameter logic [31:0] RESET_PC = id_operand_stage_pkg::RESET_PC
) (
  input logic clk,
  input logic reset,
  id_operand_stage_if.slave bus
);
  import id_operand_stage_pkg::*;

  logic              r_valid;
  logic [31:0]       r_pc;
  logic [31:0]       r_inst;
  logic [REG_W-1:0]  w_rs;
  logic [REG_W-1:0]  w_rt;
  logic              w_stall1;
  logic              w_stall2;
  logic              w_ready_go;
  logic              w_allowin;
  logic [DATA_W-1:0] w_src1;
  logic [DATA_W-1:0] w_src2;
  fwd_src_t          w_es;
  fwd_src_t          w_ms;
  fwd_src_t          w_ws;

  assign w_rs = r_inst[RS_LSB +: REG_W];
  assign w_rt = r_inst[RT_LSB +: REG_W];

  always_comb begin
    w_es.valid   = bus.es_valid;
    w_es.dest    = bus.es_dest;
    w_es.is_load = bus.es_is_load;
    w_es.data_ok = 1'b0;
    w_es.result  = bus.es_result;
    w_ms.valid   = bus.ms_valid;
    w_ms.dest    = bus.ms_dest;
    w_ms.is_load = bus.ms_is_load;
    w_ms.data_ok = bus.ms_data_ok;
    w_ms.result  = bus.ms_result;
    w_ws.valid   = bus.ws_valid;
    w_ws.dest    = bus.ws_dest;
    w_ws.is_load = 1'b0;
    w_ws.data_ok = 1'b1;
    w_ws.result  = bus.ws_result;
  end

  id_fwd_mux u_fwd_rs (
    .i_src   (w_rs),
    .i_es    (w_es),
    .i_ms    (w_ms),
    .i_ws    (w_ws),
    .i_rdata (bus.rdata1),
    .o_value (w_src1),
    .o_stall (w_stall1)
  );

  id_fwd_mux u_fwd_rt (
    .i_src   (w_rt),
    .i_es    (w_es),
    .i_ms    (w_ms),
    .i_ws    (w_ws),
    .i_rdata (bus.rdata2),
    .o_value (w_src2),
    .o_stall (w_stall2)
  );

  assign w_ready_go = !(w_stall1 || w_stall2);
  assign w_allowin  = !r_valid || (w_ready_go && bus.es_allowin);

  // Flush outranks capture so an offer arriving with it is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_allowin) begin
      r_valid <= bus.fs_to_ds_valid;
      if (bus.fs_to_ds_valid) begin
        r_pc   <= bus.fs_pc;
        r_inst <= bus.fs_inst;
      end
    end
  end

  assign bus.ds_allowin     = w_allowin;
  assign bus.ds_to_es_valid = r_valid && w_ready_go && !bus.flush;
  assign bus.raddr1         = w_rs;
  assign bus.raddr2         = w_rt;
  assign bus.ds_pc          = r_pc;
  assign bus.ds_inst        = r_inst;
  assign bus.ds_src1        = w_src1;
  assign bus.ds_src2        = w_src2;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed and randomized bench for id_operand_stage against a behavioural operand model.
module tb_id_operand_stage;
  import id_operand_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_operand_stage_if bus();
  logic [31:0] rf [32];

  assign bus.rdata1 = rf[bus.raddr1];
  assign bus.rdata2 = rf[bus.raddr2];

  id_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Operand value from the youngest live writer of src; stall as the hazard rules dictate.
  function automatic void ref_operand(input logic [4:0] src, output logic [31:0] val,
                                      output logic stl);
    logic        v [3];
    logic [4:0]  d [3];
    logic [31:0] r [3];
    logic        hit [3];
    v = '{bus.es_valid, bus.ms_valid, bus.ws_valid};
    d = '{bus.es_dest, bus.ms_dest, bus.ws_dest};
    r = '{bus.es_result, bus.ms_result, bus.ws_result};
    for (int i = 0; i < 3; i++) hit[i] = v[i] && (d[i] != 0) && (d[i] == src);
    val = rf[src];
`ifdef BYPASS_EN
    for (int i = 2; i >= 0; i--) if (hit[i]) val = r[i];
    stl = (hit[0] && bus.es_is_load) || (hit[1] && bus.ms_is_load && !bus.ms_data_ok);
`else
    stl = hit[0] || hit[1] || hit[2];
`endif
    if (src == 0) val = 32'h0;
  endfunction

  task automatic check_cycle();
    logic [31:0] v1, v2;
    logic        s1, s2, stall, allow, to_es;
    #1;
    ref_operand(m_inst[25:21], v1, s1);
    ref_operand(m_inst[20:16], v2, s2);
    stall = s1 || s2;
    allow = !m_valid || (!stall && bus.es_allowin);
    to_es = m_valid && !stall && !bus.flush;
    chk("allowin", {31'b0, bus.ds_allowin}, {31'b0, allow});
    chk("to_es_valid", {31'b0, bus.ds_to_es_valid}, {31'b0, to_es});
    chk("raddr1", {27'b0, bus.raddr1}, {27'b0, m_inst[25:21]});
    chk("raddr2", {27'b0, bus.raddr2}, {27'b0, m_inst[20:16]});
    chk("ds_pc", bus.ds_pc, m_pc);
    chk("ds_inst", bus.ds_inst, m_inst);
    if (m_valid && !stall) begin
      chk("src1", bus.ds_src1, v1);
      chk("src2", bus.ds_src2, v2);
    end
    if (reset) begin
      m_valid = 1'b0;
      m_pc    = RESET_PC;
      m_inst  = 32'h0;
    end else if (bus.flush) begin
      m_valid = 1'b0;
    end else if (allow) begin
      m_valid = bus.fs_to_ds_valid;
      if (bus.fs_to_ds_valid) begin
        m_pc   = bus.fs_pc;
        m_inst = bus.fs_inst;
      end
    end
  endtask

  task automatic idle();
    bus.flush = 0; bus.fs_to_ds_valid = 0;
    bus.es_valid = 0; bus.es_dest = 0; bus.es_is_load = 0; bus.es_result = 0;
    bus.ms_valid = 0; bus.ms_dest = 0; bus.ms_is_load = 0; bus.ms_data_ok = 0; bus.ms_result = 0;
    bus.ws_valid = 0; bus.ws_dest = 0; bus.ws_result = 0;
    bus.es_allowin = 1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    bus.fs_to_ds_valid = 1; bus.fs_pc = pc; bus.fs_inst = inst;
    check_cycle();
    @(negedge clk);
    bus.fs_to_ds_valid = 0;
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, 16'h0020};
  endfunction

  initial begin
    rf[0] = 32'h0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    idle();
    bus.fs_pc = 0; bus.fs_inst = 0;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    m_valid = 0; m_pc = RESET_PC; m_inst = 0;
    #1;
    chk("rst_pc", bus.ds_pc, 32'hBFC0_0000);
    chk("rst_inst", bus.ds_inst, 32'h0);
    chk("rst_to_es", {31'b0, bus.ds_to_es_valid}, 32'h0);
    chk("rst_allowin", {31'b0, bus.ds_allowin}, 32'h1);
    @(negedge clk);
    reset = 0;

    // First fetch after reset passes through in one cycle.
    offer(32'hBFC0_0004, mk_inst(5'd2, 5'd3));
    check_cycle();
    chk("first_to_es", {31'b0, bus.ds_to_es_valid}, 32'h1);
    chk("first_pc", bus.ds_pc, 32'hBFC0_0004);
    @(negedge clk);

    // EX and MEM both write r8.
    offer(32'hBFC0_0008, mk_inst(5'd8, 5'd0));
    bus.es_valid = 1; bus.es_dest = 8; bus.es_result = 32'h1234;
    bus.ms_valid = 1; bus.ms_dest = 8; bus.ms_result = 32'h5555;
    check_cycle();
`ifdef BYPASS_EN
    chk("ex_prio_src1", bus.ds_src1, 32'h1234);
    chk("ex_prio_to_es", {31'b0, bus.ds_to_es_valid}, 32'h1);
`else
    chk("nobyp_stall", {31'b0, bus.ds_allowin}, 32'h0);
`endif
    @(negedge clk);
    idle();
    check_cycle();
    @(negedge clk);

    // Load-use on rt.
    offer(32'hBFC0_000C, mk_inst(5'd1, 5'd9));
    bus.es_valid = 1; bus.es_dest = 9; bus.es_is_load = 1; bus.es_result = 32'hDEAD;
    check_cycle();
    chk("lu_allowin", {31'b0, bus.ds_allowin}, 32'h0);
    chk("lu_to_es", {31'b0, bus.ds_to_es_valid}, 32'h0);
    @(negedge clk);
    idle();
    bus.ms_valid = 1; bus.ms_dest = 9; bus.ms_is_load = 1; bus.ms_data_ok = 1;
    bus.ms_result = 32'hCAFE_0009;
    check_cycle();
`ifdef BYPASS_EN
    chk("lu_fwd_src2", bus.ds_src2, 32'hCAFE_0009);
    chk("lu_fwd_to_es", {31'b0, bus.ds_to_es_valid}, 32'h1);
`else
    chk("lu_nobyp_stall", {31'b0, bus.ds_allowin}, 32'h0);
`endif
    @(negedge clk);
    idle();
    check_cycle();
    @(negedge clk);

    // r0 is never forwarded.
    offer(32'hBFC0_0010, mk_inst(5'd0, 5'd0));
    bus.es_valid = 1; bus.es_dest = 0; bus.es_result = 32'hFFFF;
    check_cycle();
    chk("r0_src1", bus.ds_src1, 32'h0);
    chk("r0_to_es", {31'b0, bus.ds_to_es_valid}, 32'h1);
    @(negedge clk);
    idle();

    // EX back-pressure holds the instruction and refuses new offers.
    offer(32'hBFC0_0014, 32'h0123_4567);
    for (int k = 0; k < 3; k++) begin
      bus.es_allowin = 0;
      bus.fs_to_ds_valid = 1; bus.fs_pc = 32'h1111_0000 + k; bus.fs_inst = 32'hFFFF_0000;
      check_cycle();
      chk("bp_pc", bus.ds_pc, 32'hBFC0_0014);
      chk("bp_inst", bus.ds_inst, 32'h0123_4567);
      chk("bp_allowin", {31'b0, bus.ds_allowin}, 32'h0);
      @(negedge clk);
    end
    bus.fs_to_ds_valid = 0; bus.es_allowin = 1;
    check_cycle();
    chk("bp_release", {31'b0, bus.ds_to_es_valid}, 32'h1);
    @(negedge clk);

    // Flush while stalled, with a concurrent offer that must be dropped.
    offer(32'hBFC0_0018, mk_inst(5'd1, 5'd9));
    bus.es_valid = 1; bus.es_dest = 9; bus.es_is_load = 1;
    bus.flush = 1; bus.fs_to_ds_valid = 1; bus.fs_pc = 32'hBFC0_001C; bus.fs_inst = 32'h0;
    check_cycle();
    chk("flush_to_es", {31'b0, bus.ds_to_es_valid}, 32'h0);
    @(negedge clk);
    idle();
    check_cycle();
    chk("flush_allowin", {31'b0, bus.ds_allowin}, 32'h1);
    chk("flush_to_es_next", {31'b0, bus.ds_to_es_valid}, 32'h0);
    @(negedge clk);

    // Randomized traffic with small register indices to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      bus.flush          = ($urandom_range(0, 19) == 0);
      bus.fs_to_ds_valid = ($urandom_range(0, 9) < 7);
      bus.fs_pc          = $urandom;
      bus.fs_inst        = {6'($urandom_range(0, 63)), 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3)), 16'($urandom)};
      bus.es_valid   = $urandom_range(0, 1);
      bus.es_dest    = 5'($urandom_range(0, 3));
      bus.es_is_load = ($urandom_range(0, 3) == 0);
      bus.es_result  = $urandom;
      bus.ms_valid   = $urandom_range(0, 1);
      bus.ms_dest    = 5'($urandom_range(0, 3));
      bus.ms_is_load = $urandom_range(0, 1);
      bus.ms_data_ok = $urandom_range(0, 1);
      bus.ms_result  = $urandom;
      bus.ws_valid   = $urandom_range(0, 1);
      bus.ws_dest    = 5'($urandom_range(0, 3));
      bus.ws_result  = $urandom;
      bus.es_allowin = ($urandom_range(0, 3) != 0);
      check_cycle();
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
